// File: rtl/program_loader_pkg.sv
// Shared state encoding and error codes for the FRANK6000 program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_CRST  = 3'd5,
    ST_RUN   = 3'd6,
    ST_FIN   = 3'd7
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_TOUT = 2'b10;

endpackage

// File: rtl/program_loader.sv
// Byte-stream frame loader: writes a checksummed program into CPU instruction
// memory, starts the CPU, and reports the WREG value at the end-of-program loop.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int RUN_TIMEOUT = 65535,
  parameter int CNT_WIDTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_instr_addr,
  output logic [15:0] o_instr,
  output logic        o_we,
  output logic        o_cpu_rst,
  output logic        o_ON,
  input  logic        i_loopf,
  input  logic [7:0]  i_WREG,
  output logic [7:0]  o_result,
  output logic        o_done,
  output logic [1:0]  o_err,
  output logic        o_busy
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(RUN_TIMEOUT);

  state_t               state_reg, state_next;
  logic [7:0]           count_reg, addr_reg, chk_reg, result_reg;
  logic [15:0]          instr_reg;
  logic [1:0]           err_reg;
  logic [CNT_WIDTH-1:0] run_cnt_reg;
  logic                 last_word, chk_ok, timeout_hit;

  // A count of 0 wraps to 255 here, which is exactly the 256-word case.
  assign last_word   = (addr_reg == count_reg - 8'd1);
  assign chk_ok      = (chk_reg == i_byte);
  assign timeout_hit = (run_cnt_reg == TIMEOUT_VAL);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Control outputs decode the state directly so reset drops them at once.
  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_we       = 1'b0;
    o_cpu_rst  = 1'b0;
    o_ON       = 1'b0;
    o_done     = 1'b0;
    case (state_reg)
      ST_IDLE:  begin o_ready = 1'b1; if (i_valid) state_next = ST_HI; end
      ST_HI:    begin o_ready = 1'b1; if (i_valid) state_next = ST_LO; end
      ST_LO:    begin o_ready = 1'b1; if (i_valid) state_next = ST_WRITE; end
      ST_WRITE: begin o_we = 1'b1; state_next = last_word ? ST_CHK : ST_HI; end
      ST_CHK: begin
        o_ready = 1'b1;
        if (i_valid) state_next = chk_ok ? ST_CRST : ST_FIN;
      end
      ST_CRST:  begin o_cpu_rst = 1'b1; state_next = ST_RUN; end
      ST_RUN: begin
        o_ON = 1'b1;
        if (i_loopf || timeout_hit) state_next = ST_FIN;
      end
      ST_FIN:   begin o_done = 1'b1; state_next = ST_IDLE; end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count_reg   <= '0;
      addr_reg    <= '0;
      chk_reg     <= '0;
      instr_reg   <= '0;
      err_reg     <= ERR_OK;
      result_reg  <= '0;
      run_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (i_valid) begin
          count_reg <= i_byte;
          addr_reg  <= '0;
          chk_reg   <= '0;
          err_reg   <= ERR_OK;
        end
        ST_HI: if (i_valid) begin
          instr_reg[15:8] <= i_byte;
          chk_reg         <= chk_reg ^ i_byte;
        end
        ST_LO: if (i_valid) begin
          instr_reg[7:0] <= i_byte;
          chk_reg        <= chk_reg ^ i_byte;
        end
        ST_WRITE: if (!last_word) addr_reg <= addr_reg + 8'd1;
        ST_CHK:   if (i_valid && !chk_ok) err_reg <= ERR_CHK;
        ST_CRST:  run_cnt_reg <= '0;
        ST_RUN: begin
          run_cnt_reg <= run_cnt_reg + 1'b1;
          // Loop flag wins over a simultaneous timeout.
          if (i_loopf)          result_reg <= i_WREG;
          else if (timeout_hit) err_reg    <= ERR_TOUT;
        end
        default: ;
      endcase
    end
  end

  assign o_instr_addr = addr_reg;
  assign o_instr      = instr_reg;
  assign o_result     = result_reg;
  assign o_err        = err_reg;
  assign o_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame-level bench for program_loader with a queue-based reference model.
module tb_program_loader;

  localparam int TOUT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_byte = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  o_instr_addr;
  logic [15:0] o_instr;
  logic        o_we, o_cpu_rst, o_ON, o_done, o_busy;
  logic        i_loopf = 1'b0;
  logic [7:0]  i_WREG = '0;
  logic [7:0]  o_result;
  logic [1:0]  o_err;

  program_loader #(.RUN_TIMEOUT(TOUT), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_byte(i_byte), .i_valid(i_valid),
    .o_ready(o_ready), .o_instr_addr(o_instr_addr), .o_instr(o_instr),
    .o_we(o_we), .o_cpu_rst(o_cpu_rst), .o_ON(o_ON), .i_loopf(i_loopf),
    .i_WREG(i_WREG), .o_result(o_result), .o_done(o_done), .o_err(o_err),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected memory writes as {addr, data}, consumed in order by the monitor.
  logic [23:0] exp_q[$];
  logic [15:0] preset_q[$];
  bit mon_en = 1'b0;
  int on_cycles, rst_pulses, done_pulses;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_we) begin
        if (exp_q.size() == 0) check("write_extra", 1, 0);
        else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("write_addr", o_instr_addr, e[23:16]);
          check("write_data", o_instr, e[15:0]);
        end
      end
      if (o_ON)      on_cycles++;
      if (o_cpu_rst) rst_pulses++;
      if (o_done)    done_pulses++;
    end
  end

  // Called at a negedge; returns at the negedge after the byte is transferred.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    while (stall && $urandom_range(0, 2) == 0) begin
      i_valid = 1'b0;
      @(negedge clk);
    end
    i_valid = 1'b1;
    i_byte  = b;
    while (!o_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 0, 1);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // One frame: n=0 means 256 words; chk_mask!=0 corrupts the checksum;
  // do_loop raises i_loopf d cycles after o_ON first appears.
  task automatic run_frame(input int n, input logic [7:0] chk_mask, input bit do_loop,
                           input int d, input logic [7:0] wreg, input bit stall);
    logic [15:0] w[$];
    logic [7:0]  cs = 8'h00;
    int nw, guard, exp_on;
    logic [1:0] exp_err;
    nw = (n == 0) ? 256 : n;
    exp_q.delete();
    on_cycles = 0; rst_pulses = 0; done_pulses = 0;
    for (int i = 0; i < nw; i++) begin
      logic [15:0] word;
      word = (preset_q.size() > i) ? preset_q[i] : 16'($urandom);
      w.push_back(word);
      cs = cs ^ word[15:8] ^ word[7:0];
      exp_q.push_back({8'(i), word});
    end
    send_byte(8'(n), stall);
    for (int i = 0; i < nw; i++) begin
      logic [15:0] word;
      word = w[i];
      send_byte(word[15:8], stall);
      send_byte(word[7:0], stall);
    end
    send_byte(cs ^ chk_mask, stall);
    if (chk_mask == 8'h00) begin
      guard = 0;
      while (!o_ON && guard < 10) begin @(negedge clk); guard++; end
      if (guard >= 10) check("on_timeout", 0, 1);
      if (do_loop) begin
        repeat (d) @(negedge clk);
        i_WREG  = wreg;
        i_loopf = 1'b1;
        @(negedge clk);
        i_loopf = 1'b0;
        check("done_after_loop", o_done, 1);
        check("on_low_at_done", o_ON, 0);
      end
    end
    guard = 0;
    while (o_busy && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) check("idle_timeout", 0, 1);
    if (chk_mask != 8'h00) begin exp_err = 2'b01; exp_on = 0; end
    else if (do_loop)      begin exp_err = 2'b00; exp_on = d + 1; end
    else                   begin exp_err = 2'b10; exp_on = TOUT + 1; end
    check("writes_left", exp_q.size(), 0);
    check("done_pulses", done_pulses, 1);
    check("err", o_err, exp_err);
    check("on_cycles", on_cycles, exp_on);
    check("cpu_rst_pulses", rst_pulses, (chk_mask == 8'h00) ? 1 : 0);
    if (chk_mask == 8'h00 && do_loop) check("result", o_result, wreg);
    $display("frame n=%0d mask=%0h loop=%0b d=%0d stall=%0b err=%0b result=%0h",
             n, chk_mask, do_loop, d, stall, o_err, o_result);
  endtask

  task automatic reset_mid_run();
    logic [15:0] word;
    int guard = 0;
    mon_en = 1'b0;
    word = 16'($urandom);
    send_byte(8'd1, 1'b0);
    send_byte(word[15:8], 1'b0);
    send_byte(word[7:0], 1'b0);
    send_byte(word[15:8] ^ word[7:0], 1'b0);
    while (!o_ON && guard < 10) begin @(negedge clk); guard++; end
    check("rst_run_on", o_ON, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_on", o_ON, 0);
    check("rst_async_busy", o_busy, 0);
    check("rst_async_ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after_ready", o_ready, 1);
    $display("reset mid-run: on=%0b busy=%0b ready=%0b", o_ON, o_busy, o_ready);
    mon_en = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_ready", o_ready, 1);
    check("reset_outs", {o_we, o_cpu_rst, o_ON, o_done, o_busy, o_err, o_result, o_instr_addr, o_instr}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    preset_q = '{16'hA105, 16'h0000};
    run_frame(2, 8'h00, 1'b1, 3, 8'h3C, 1'b0);
    run_frame(2, 8'h01, 1'b0, 0, 8'h00, 1'b0);
    preset_q.delete();

    run_frame(0, 8'h00, 1'b1, $urandom_range(0, 9), 8'($urandom), 1'b0);
    run_frame($urandom_range(1, 8), 8'h00, 1'b0, 0, 8'h00, 1'b0);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 12);
      case (k % 3)
        0: run_frame(n, 8'h00, 1'b1, $urandom_range(0, 9), 8'($urandom), 1'b1);
        1: run_frame(n, 8'($urandom_range(1, 255)), 1'b0, 0, 8'h00, 1'b1);
        default: run_frame(n, 8'h00, 1'b0, 0, 8'h00, 1'b1);
      endcase
    end

    reset_mid_run();
    run_frame($urandom_range(1, 6), 8'h00, 1'b1, $urandom_range(0, 9), 8'($urandom), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
